// File: rtl/cv_ctrl_pkg.sv
// cv_ctrl_pkg: keypad code constants, joystick-word bit indices and scanner FSM states.
package cv_ctrl_pkg;

    localparam int JOY_W = 20;

    localparam logic [3:0] KC_0    = 4'b0011;
    localparam logic [3:0] KC_1    = 4'b1110;
    localparam logic [3:0] KC_2    = 4'b1101;
    localparam logic [3:0] KC_3    = 4'b0110;
    localparam logic [3:0] KC_4    = 4'b0001;
    localparam logic [3:0] KC_5    = 4'b1001;
    localparam logic [3:0] KC_6    = 4'b0111;
    localparam logic [3:0] KC_7    = 4'b1100;
    localparam logic [3:0] KC_8    = 4'b1000;
    localparam logic [3:0] KC_9    = 4'b1011;
    localparam logic [3:0] KC_STAR = 4'b1010;
    localparam logic [3:0] KC_HASH = 4'b0101;
    localparam logic [3:0] KC_PT   = 4'b0100;
    localparam logic [3:0] KC_BT   = 4'b0010;
    localparam logic [3:0] KC_NONE = 4'b1111;

    localparam int B_RIGHT = 0;
    localparam int B_LEFT  = 1;
    localparam int B_DOWN  = 2;
    localparam int B_UP    = 3;
    localparam int B_FIRE1 = 4;
    localparam int B_FIRE2 = 5;
    localparam int B_STAR  = 6;
    localparam int B_HASH  = 7;
    localparam int B_KEY0  = 8;
    localparam int B_PT    = 18;
    localparam int B_BT    = 19;

    typedef enum logic [1:0] {IDLE, SEL_JOY, SEL_KEY, DONE} state_t;

endpackage

// File: rtl/cv_ctrl_keydec.sv
// cv_ctrl_keydec: combinational keypad decode of one port's {p1,p2,p3,p4} code and fire line.
module cv_ctrl_keydec
    import cv_ctrl_pkg::*;
(
    input  logic [3:0]  code,
    input  logic        fire,
    output logic [19:5] bits
);

    always_comb begin
        bits = '0;
        bits[B_FIRE2] = ~fire;
        case (code)
            KC_0:    bits[B_KEY0]     = 1'b1;
            KC_1:    bits[B_KEY0 + 1] = 1'b1;
            KC_2:    bits[B_KEY0 + 2] = 1'b1;
            KC_3:    bits[B_KEY0 + 3] = 1'b1;
            KC_4:    bits[B_KEY0 + 4] = 1'b1;
            KC_5:    bits[B_KEY0 + 5] = 1'b1;
            KC_6:    bits[B_KEY0 + 6] = 1'b1;
            KC_7:    bits[B_KEY0 + 7] = 1'b1;
            KC_8:    bits[B_KEY0 + 8] = 1'b1;
            KC_9:    bits[B_KEY0 + 9] = 1'b1;
            KC_STAR: bits[B_STAR]     = 1'b1;
            KC_HASH: bits[B_HASH]     = 1'b1;
            KC_PT:   bits[B_PT]       = 1'b1;
            KC_BT:   bits[B_BT]       = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cv_ctrl_scanner.sv
// cv_ctrl_scanner: two-port controller scanner (joystick phase, then keypad phase).
// Define CV_CTRL_DEBOUNCE_EN to publish a word only after 3 identical consecutive scans.
module cv_ctrl_scanner
    import cv_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        scan_req,
    output logic        busy,
    output logic [1:0]  ctrl_p5_o,
    output logic [1:0]  ctrl_p8_o,
    input  logic [1:0]  ctrl_p1_i,
    input  logic [1:0]  ctrl_p2_i,
    input  logic [1:0]  ctrl_p3_i,
    input  logic [1:0]  ctrl_p4_i,
    input  logic [1:0]  ctrl_p6_i,
    output logic [19:0] joy0_o,
    output logic [19:0] joy1_o,
    output logic        valid_o
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic last, pub;
    logic [19:5] key [2];
    logic [19:0] raw [2];
    logic [19:0] joy [2];

    assign last = cnt == CW'(1);
    assign pub = ce && state == DONE;

    for (genvar i = 0; i < 2; i++) begin : g_dec
        cv_ctrl_keydec u_dec (
            .code ({ctrl_p1_i[i], ctrl_p2_i[i], ctrl_p3_i[i], ctrl_p4_i[i]}),
            .fire (ctrl_p6_i[i]),
            .bits (key[i])
        );
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (ce) begin
            case (state)
                IDLE: if (scan_req) begin
                    state_n = SEL_JOY;
                    cnt_n = RELOAD;
                end
                SEL_JOY: begin
                    state_n = last ? SEL_KEY : SEL_JOY;
                    cnt_n = last ? RELOAD : cnt - CW'(1);
                end
                SEL_KEY: begin
                    state_n = last ? DONE : SEL_KEY;
                    cnt_n = last ? '0 : cnt - CW'(1);
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = state != IDLE;
    assign ctrl_p8_o = state == SEL_JOY ? 2'b00 : 2'b11;
    assign ctrl_p5_o = state == SEL_KEY ? 2'b00 : 2'b11;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            valid_o <= 1'b0;
            for (int i = 0; i < 2; i++) raw[i] <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            valid_o <= pub;
            for (int i = 0; i < 2; i++) begin
                if (ce && last && state == SEL_JOY)
                    raw[i][4:0] <= ~{ctrl_p6_i[i], ctrl_p1_i[i], ctrl_p2_i[i], ctrl_p3_i[i], ctrl_p4_i[i]};
                if (ce && last && state == SEL_KEY)
                    raw[i][19:5] <= key[i];
            end
        end
    end

`ifdef CV_CTRL_DEBOUNCE_EN
    logic [19:0] hist [2];
    logic [1:0] seen [2];

    // seen counts consecutive identical scans (saturating); third match publishes
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                joy[i] <= '0;
                hist[i] <= '0;
                seen[i] <= '0;
            end
        end else if (pub) begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == hist[i]) begin
                    seen[i] <= seen[i] == 2'd3 ? 2'd3 : seen[i] + 2'd1;
                    if (seen[i] >= 2'd2) joy[i] <= raw[i];
                end else begin
                    hist[i] <= raw[i];
                    seen[i] <= 2'd1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) joy[i] <= '0;
        end else if (pub) begin
            for (int i = 0; i < 2; i++) joy[i] <= raw[i];
        end
    end
`endif

    assign joy0_o = joy[0];
    assign joy1_o = joy[1];

endmodule

// File: tb/tb_cv_ctrl_scanner.sv
// tb_cv_ctrl_scanner: table-driven check of cv_ctrl_scanner with a strobe-driven controller model.
module tb_cv_ctrl_scanner;

    logic clk_sys = 1'b0;
    logic reset, ce, scan_req, busy, valid_o;
    logic [1:0] ctrl_p5_o, ctrl_p8_o, ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i;
    logic [19:0] joy0_o, joy1_o;

    // per-port line levels {p1,p2,p3,p4,p6} presented while each strobe is low
    logic [4:0] jp [2];
    logic [4:0] kp [2];
    logic [4:0] ln0, ln1;

    int vecs = 0;
    int miss = 0;

`ifdef CV_CTRL_DEBOUNCE_EN
    localparam int REPS = 3;
`else
    localparam int REPS = 1;
`endif

    typedef struct {
        logic [4:0]  jp0, kp0, jp1, kp1;
        logic [19:0] e0, e1;
    } vec_t;

    always #5 clk_sys = ~clk_sys;

    assign ln0 = !ctrl_p8_o[0] ? jp[0] : !ctrl_p5_o[0] ? kp[0] : 5'h1F;
    assign ln1 = !ctrl_p8_o[1] ? jp[1] : !ctrl_p5_o[1] ? kp[1] : 5'h1F;
    assign ctrl_p1_i = {ln1[4], ln0[4]};
    assign ctrl_p2_i = {ln1[3], ln0[3]};
    assign ctrl_p3_i = {ln1[2], ln0[2]};
    assign ctrl_p4_i = {ln1[1], ln0[1]};
    assign ctrl_p6_i = {ln1[0], ln0[0]};

    cv_ctrl_scanner #(.SETTLE_CYC(4)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ce        (ce),
        .scan_req  (scan_req),
        .busy      (busy),
        .ctrl_p5_o (ctrl_p5_o),
        .ctrl_p8_o (ctrl_p8_o),
        .ctrl_p1_i (ctrl_p1_i),
        .ctrl_p2_i (ctrl_p2_i),
        .ctrl_p3_i (ctrl_p3_i),
        .ctrl_p4_i (ctrl_p4_i),
        .ctrl_p6_i (ctrl_p6_i),
        .joy0_o    (joy0_o),
        .joy1_o    (joy1_o),
        .valid_o   (valid_o)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_pat(input logic [4:0] j0, input logic [4:0] k0, input logic [4:0] j1, input logic [4:0] k1);
        jp[0] = j0;
        kp[0] = k0;
        jp[1] = j1;
        kp[1] = k1;
    endtask

    // one full scan at ce=1: acceptance, valid latency, pulse width
    task automatic scan;
        int lat;
        scan_req = 1'b1;
        tick;
        scan_req = 1'b0;
        check("busy_after_accept", busy, 1);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 100) begin
            tick;
            lat++;
        end
        check("valid_latency", lat, 9);
        check("busy_after_done", busy, 0);
        tick;
        check("valid_width", valid_o, 0);
    endtask

    initial begin
        vec_t tbl [11];
        int vcount, overlap, holdbad;
        logic [1:0] p5b, p8b;
        tbl[0]  = '{5'b01110, 5'b11111, 5'b11111, 5'b11111, 20'h00018, 20'h00000};
        tbl[1]  = '{5'b11111, 5'b11111, 5'b11111, 5'b10100, 20'h00000, 20'h00060};
        tbl[2]  = '{5'b11111, 5'b00001, 5'b11111, 5'b00001, 20'h00000, 20'h00000};
        tbl[3]  = '{5'b11101, 5'b10011, 5'b10111, 5'b01000, 20'h02001, 20'h40024};
        tbl[4]  = '{5'b00000, 5'b00111, 5'b11111, 5'b00101, 20'h0011F, 20'h80000};
        tbl[5]  = '{5'b11111, 5'b01011, 5'b11111, 5'b10111, 20'h00080, 20'h20000};
        tbl[6]  = '{5'b11111, 5'b11101, 5'b11111, 5'b01111, 20'h00200, 20'h04000};
        tbl[7]  = '{5'b11111, 5'b11011, 5'b11111, 5'b01101, 20'h00400, 20'h00800};
        tbl[8]  = '{5'b11111, 5'b00011, 5'b11111, 5'b11001, 20'h01000, 20'h08000};
        tbl[9]  = '{5'b11111, 5'b10001, 5'b11111, 5'b11111, 20'h10000, 20'h00000};
        tbl[10] = '{5'b11111, 5'b11111, 5'b11111, 5'b11111, 20'h00000, 20'h00000};

        reset = 1'b1;
        ce = 1'b1;
        scan_req = 1'b0;
        set_pat(5'h1F, 5'h1F, 5'h1F, 5'h1F);
        tick;
        tick;
        check("rst_p5", ctrl_p5_o, 2'b11);
        check("rst_p8", ctrl_p8_o, 2'b11);
        check("rst_busy", busy, 0);
        check("rst_valid", valid_o, 0);
        check("rst_joy0", joy0_o, 0);
        check("rst_joy1", joy1_o, 0);
        reset = 1'b0;
        tick;

`ifdef CV_CTRL_DEBOUNCE_EN
        set_pat(5'h1F, 5'b10011, 5'h1F, 5'h1F);
        scan;
        check("deb_scan1", joy0_o, 0);
        scan;
        check("deb_scan2", joy0_o, 0);
        scan;
        check("deb_scan3", joy0_o, 20'h02000);
`endif

        for (int v = 0; v < 11; v++) begin
            set_pat(tbl[v].jp0, tbl[v].kp0, tbl[v].jp1, tbl[v].kp1);
            for (int r = 0; r < REPS; r++) scan;
            check($sformatf("vec%0d_joy0", v), joy0_o, tbl[v].e0);
            check($sformatf("vec%0d_joy1", v), joy1_o, tbl[v].e1);
        end

        // ce at half rate, second request lands mid-scan
        set_pat(tbl[3].jp0, tbl[3].kp0, tbl[3].jp1, tbl[3].kp1);
        vcount = 0;
        overlap = 0;
        holdbad = 0;
        for (int c = 0; c < 60; c++) begin
            ce = (c % 2) == 0;
            scan_req = c == 0 || c == 10;
            p5b = ctrl_p5_o;
            p8b = ctrl_p8_o;
            tick;
            if (valid_o) vcount++;
            if ((~ctrl_p5_o & ~ctrl_p8_o) != 2'b00) overlap++;
            if (!ce && (ctrl_p5_o != p5b || ctrl_p8_o != p8b)) holdbad++;
        end
        ce = 1'b1;
        scan_req = 1'b0;
        check("ce_valid_count", vcount, 1);
        check("ce_strobe_overlap", overlap, 0);
        check("ce_strobe_hold", holdbad, 0);
`ifdef CV_CTRL_DEBOUNCE_EN
        check("ce_joy0", joy0_o, 20'h00000);
        check("ce_joy1", joy1_o, 20'h00000);
`else
        check("ce_joy0", joy0_o, 20'h02001);
        check("ce_joy1", joy1_o, 20'h40024);
`endif

        // asynchronous reset while in the keypad phase
        set_pat(tbl[0].jp0, tbl[0].kp0, tbl[0].jp1, tbl[0].kp1);
        scan_req = 1'b1;
        tick;
        scan_req = 1'b0;
        repeat (6) tick;
        check("selkey_p5", ctrl_p5_o, 2'b00);
        check("selkey_p8", ctrl_p8_o, 2'b11);
        #2 reset = 1'b1;
        #1;
        check("midrst_p5", ctrl_p5_o, 2'b11);
        check("midrst_p8", ctrl_p8_o, 2'b11);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid_o, 0);
        check("midrst_joy0", joy0_o, 0);
        check("midrst_joy1", joy1_o, 0);
        #1 reset = 1'b0;
        vcount = 0;
        for (int c = 0; c < 30; c++) begin
            tick;
            if (valid_o || busy) vcount++;
        end
        check("postrst_idle", vcount, 0);

        for (int r = 0; r < REPS; r++) scan;
        check("recover_joy0", joy0_o, tbl[0].e0);
        check("recover_joy1", joy1_o, tbl[0].e1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
